// File: rtl/hit_tracker.sv
// hit_tracker
//   Collision bookkeeping for the alien/missile game. During PLAY, every pixel
//   where a live alien sprite and any missile sprite are both drawn marks that
//   alien as hit and the missiles drawn there as spent. The marks gather in
//   pending sets for the whole frame. On frame_tick the pending sets are
//   committed in one blanking cycle (COMMIT): hit aliens die, spent missiles
//   get a one-cycle missle_clear pulse, and the score counts the kills.
//   Killing the last alien ends in WON. Aliens landing while in PLAY end in LOST.
//
// Optional feature:
//   HIT_TRACKER_SCORE_EN - when defined, a saturating kill counter drives
//                          score. When undefined, score is tied to zero.
//
// Ports:
//   vga_clk_i     in   pixel clock, the only clock
//   vga_rst_i     in   synchronous reset, active low
//   alien_active  in   [NUM_ALIENS]  alien sprite coverage of the current pixel
//   missle_active in   [NUM_MISSLES] missile sprite coverage of the current pixel
//   frame_tick    in   one-cycle pulse at start of vertical blanking
//   landed        in   aliens reached the player row
//   restart       in   one-cycle pulse requesting a new game
//   alien_alive   out  [NUM_ALIENS]  registered alive mask
//   missle_clear  out  [NUM_MISSLES] one-cycle pulse retiring missiles that hit
//   score         out  [SCORE_W]     registered kill count
//   winner        out  high while in WON
//   loser         out  high while in LOST
module hit_tracker #(
  parameter int NUM_ALIENS  = 5,
  parameter int NUM_MISSLES = 8,
  parameter int SCORE_W     = 8
) (
  input  logic                   vga_clk_i,
  input  logic                   vga_rst_i,
  input  logic [NUM_ALIENS-1:0]  alien_active,
  input  logic [NUM_MISSLES-1:0] missle_active,
  input  logic                   frame_tick,
  input  logic                   landed,
  input  logic                   restart,
  output logic [NUM_ALIENS-1:0]  alien_alive,
  output logic [NUM_MISSLES-1:0] missle_clear,
  output logic [SCORE_W-1:0]     score,
  output logic                   winner,
  output logic                   loser
);

  typedef enum logic [1:0] {PLAY, COMMIT, WON, LOST} state_t;

  state_t                 state, state_d;
  logic [NUM_ALIENS-1:0]  pend_hit, pend_hit_d;
  logic [NUM_MISSLES-1:0] pend_miss, pend_miss_d;
  logic [NUM_ALIENS-1:0]  alive_d;
  logic [NUM_MISSLES-1:0] clear_d;
  logic [NUM_ALIENS-1:0]  live_cover;

  // Only aliens that are still alive can be hit; dead sprites are not drawn.
  assign live_cover = alien_active & alien_alive;

  // Next-state and next-value logic. Restart beats everything except reset.
  // A landing seen in PLAY throws away the frame's pending hits, and it wins
  // over a frame_tick in the same cycle. COMMIT ignores all collision inputs
  // because the screen is blanked.
  always_comb begin
    state_d     = state;
    alive_d     = alien_alive;
    pend_hit_d  = pend_hit;
    pend_miss_d = pend_miss;
    clear_d     = '0;
    if (restart) begin
      state_d     = PLAY;
      alive_d     = '1;
      pend_hit_d  = '0;
      pend_miss_d = '0;
    end else begin
      case (state)
        PLAY: begin
          if (landed) begin
            state_d     = LOST;
            pend_hit_d  = '0;
            pend_miss_d = '0;
          end else begin
            pend_hit_d  = pend_hit | (live_cover & {NUM_ALIENS{|missle_active}});
            pend_miss_d = pend_miss | (missle_active & {NUM_MISSLES{|live_cover}});
            if (frame_tick) begin
              state_d = COMMIT;
            end
          end
        end
        COMMIT: begin
          alive_d     = alien_alive & ~pend_hit;
          clear_d     = pend_miss;
          pend_hit_d  = '0;
          pend_miss_d = '0;
          state_d     = (alive_d == '0) ? WON : PLAY;
        end
        default: begin
          state_d = state;
        end
      endcase
    end
  end

  // State and output registers. winner/loser come from the next state, so
  // they line up exactly with the state register.
  always_ff @(posedge vga_clk_i) begin
    if (!vga_rst_i) begin
      state        <= PLAY;
      alien_alive  <= '1;
      pend_hit     <= '0;
      pend_miss    <= '0;
      missle_clear <= '0;
      winner       <= 1'b0;
      loser        <= 1'b0;
    end else begin
      state        <= state_d;
      alien_alive  <= alive_d;
      pend_hit     <= pend_hit_d;
      pend_miss    <= pend_miss_d;
      missle_clear <= clear_d;
      winner       <= (state_d == WON);
      loser        <= (state_d == LOST);
    end
  end

`ifdef HIT_TRACKER_SCORE_EN
  localparam int CNT_W = $clog2(NUM_ALIENS + 1);
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

  logic [CNT_W-1:0]   hit_count;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_q, score_d;

  // Kills in this commit, added with one spare bit so the sum can be clamped
  // at the top of the counter range rather than wrapping back to zero.
  always_comb begin
    hit_count = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      hit_count = hit_count + CNT_W'(pend_hit[i]);
    end
    score_sum = SUM_W'(score_q) + SUM_W'(hit_count);
    score_d   = score_q;
    if (restart) begin
      score_d = '0;
    end else if (state == COMMIT) begin
      if (score_sum > SUM_W'({SCORE_W{1'b1}})) begin
        score_d = '1;
      end else begin
        score_d = score_sum[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge vga_clk_i) begin
    if (!vga_rst_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_hit_tracker.sv
// tb_hit_tracker
//   Drives two hit_tracker instances with identical stimulus: one with the
//   default 8-bit score and one with a 2-bit score to exercise saturation.
//   Each scenario is a table of cycles: inputs to apply plus the outputs
//   expected after the next clock edge. The expected values are pushed to a
//   scoreboard queue as the stimulus is applied and popped when the DUT
//   outputs are sampled on the falling edge.
module tb_hit_tracker;

`ifdef HIT_TRACKER_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic       vga_clk_i;
  logic       vga_rst_i;
  logic [4:0] alien_active;
  logic [7:0] missle_active;
  logic       frame_tick;
  logic       landed;
  logic       restart;

  logic [4:0] alien_alive,  alien_alive2;
  logic [7:0] missle_clear, missle_clear2;
  logic [7:0] score;
  logic [1:0] score2;
  logic       winner, winner2;
  logic       loser, loser2;

  int vectors;
  int miscompares;

  typedef struct {
    logic       rst_n;
    logic [4:0] aa;
    logic [7:0] ma;
    logic       ft;
    logic       ld;
    logic       rs;
    logic [4:0] alive;
    logic [7:0] clr;
    int         sc;
    logic       win;
    logic       lose;
  } stim_t;

  typedef struct {
    string       name;
    logic [39:0] v;
  } exp_t;

  exp_t sb[$];

  hit_tracker #(.NUM_ALIENS(5), .NUM_MISSLES(8), .SCORE_W(8)) dut (
    .vga_clk_i     (vga_clk_i),
    .vga_rst_i     (vga_rst_i),
    .alien_active  (alien_active),
    .missle_active (missle_active),
    .frame_tick    (frame_tick),
    .landed        (landed),
    .restart       (restart),
    .alien_alive   (alien_alive),
    .missle_clear  (missle_clear),
    .score         (score),
    .winner        (winner),
    .loser         (loser)
  );

  hit_tracker #(.NUM_ALIENS(5), .NUM_MISSLES(8), .SCORE_W(2)) dut_sat (
    .vga_clk_i     (vga_clk_i),
    .vga_rst_i     (vga_rst_i),
    .alien_active  (alien_active),
    .missle_active (missle_active),
    .frame_tick    (frame_tick),
    .landed        (landed),
    .restart       (restart),
    .alien_alive   (alien_alive2),
    .missle_clear  (missle_clear2),
    .score         (score2),
    .winner        (winner2),
    .loser         (loser2)
  );

  initial vga_clk_i = 1'b0;
  always #5 vga_clk_i = ~vga_clk_i;

  function automatic stim_t mk(logic r, logic [4:0] aa, logic [7:0] ma,
                               logic ft, logic ld, logic rs,
                               logic [4:0] al, logic [7:0] cl, int sc,
                               logic w, logic l);
    stim_t s;
    s.rst_n = r;  s.aa = aa;   s.ma = ma;  s.ft = ft;   s.ld = ld; s.rs = rs;
    s.alive = al; s.clr = cl;  s.sc = sc;  s.win = w;   s.lose = l;
    return s;
  endfunction

  // Expected outputs of both instances packed together; the score of each
  // instance is clamped to its own width, or zero when the counter is absent.
  function automatic logic [39:0] expv(stim_t s);
    logic [7:0] sc8;
    logic [1:0] sc2;
    sc8 = SCORE_ON ? ((s.sc > 255) ? 8'd255 : 8'(s.sc)) : 8'd0;
    sc2 = SCORE_ON ? ((s.sc > 3) ? 2'd3 : 2'(s.sc)) : 2'd0;
    return {s.alive, s.clr, sc8, s.win, s.lose, s.alive, s.clr, sc2, s.win, s.lose};
  endfunction

  function automatic logic [39:0] obs();
    return {alien_alive, missle_clear, score, winner, loser,
            alien_alive2, missle_clear2, score2, winner2, loser2};
  endfunction

  task automatic apply(stim_t s);
    vga_rst_i     = s.rst_n;
    alien_active  = s.aa;
    missle_active = s.ma;
    frame_tick    = s.ft;
    landed        = s.ld;
    restart       = s.rs;
  endtask

  task automatic test_reset();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h1f, 8'hff, 1, 1, 1, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("reset[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_single_hit();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(1, 5'h01, 8'h01, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1e, 8'h01, 1, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1e, 8'h00, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("single_hit[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_multi_hit();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h03, 8'h05, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h80, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1c, 8'h05, 2, 0, 0));
    t.push_back(mk(1, 5'h01, 8'h10, 0, 0, 0, 5'h1c, 8'h00, 2, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1c, 8'h00, 2, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1c, 8'h00, 2, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("multi_hit[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_tick_overlap();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h02, 8'h02, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h04, 8'h04, 0, 0, 0, 5'h1d, 8'h02, 1, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1d, 8'h00, 1, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1d, 8'h00, 1, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1d, 8'h00, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("tick_overlap[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_landed();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h01, 8'h01, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 1, 0, 5'h1f, 8'h00, 0, 0, 1));
    t.push_back(mk(1, 5'h1f, 8'hff, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 1));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 1, 0, 5'h1f, 8'h00, 0, 0, 1));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 1, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h01, 8'h01, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1e, 8'h01, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("landed[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_win();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h1f, 8'h80, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 1, 0, 5'h00, 8'h80, 5, 1, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 1, 0, 5'h00, 8'h00, 5, 1, 0));
    t.push_back(mk(1, 5'h1f, 8'hff, 1, 1, 0, 5'h00, 8'h00, 5, 1, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("win[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  // One kill per frame until the board is empty, then a restart and a
  // sixth kill; the 2-bit instance must stick at 3 until the restart.
  task automatic test_saturate_restart();
    stim_t      t[$];
    exp_t       e;
    logic [4:0] alive;
    logic [4:0] bit_k;
    alive = 5'h1f;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      bit_k = 5'(1 << k);
      t.push_back(mk(1, bit_k, 8'(bit_k), 1, 0, 0, alive, 8'h00, k, 0, 0));
      alive = alive & ~bit_k;
      t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, alive, 8'(bit_k), k + 1, k == 4, 0));
      t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, alive, 8'h00, k + 1, k == 4, 0));
    end
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 1, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h02, 8'h02, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1d, 8'h02, 1, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1d, 8'h00, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("saturate[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_reset_in_commit();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h01, 8'h01, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 1, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    t.push_back(mk(1, 5'h00, 8'h00, 0, 0, 0, 5'h1f, 8'h00, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back('{$sformatf("reset_commit[%0d]", i), expv(t[i])});
      @(posedge vga_clk_i);
      @(negedge vga_clk_i);
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, obs(), e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    vga_rst_i     = 1'b0;
    alien_active  = '0;
    missle_active = '0;
    frame_tick    = 1'b0;
    landed        = 1'b0;
    restart       = 1'b0;
    @(negedge vga_clk_i);
    $display("[TB] score counter %s", SCORE_ON ? "enabled" : "disabled");
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_tick_overlap();
    test_landed();
    test_win();
    test_saturate_restart();
    test_reset_in_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
